// File: rtl/game_sequencer.sv
// Timing and state controller for the platform-jump game: one IDLE/PLAY/OVER FSM
// generating the scroll and sample strobes, the saturating score and the level bar.
module game_sequencer #(
    parameter int SCROLL_BASE   = 5000000,
    parameter int SCROLL_STEP   = 500000,
    parameter int SCROLL_MIN    = 500000,
    parameter int SCORE_PERIOD  = 5000000,
    parameter int SAMPLE_PERIOD = 22,
    parameter int LEVEL_PTS     = 20,
    parameter int MAX_LEVEL     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       lose,
    output logic       scroll_tick,
    output logic       sample_tick,
    output logic       running,
    output logic       game_over,
    output logic [7:0] score,
    output logic [9:0] level,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    localparam logic [31:0] SMP_LAST   = 32'(SAMPLE_PERIOD - 1);
    localparam logic [31:0] SCORE_LAST = 32'(SCORE_PERIOD - 1);
    localparam logic [7:0]  PTS_LAST   = 8'(LEVEL_PTS - 1);
    localparam logic [3:0]  LVL_MAX    = 4'(MAX_LEVEL);

    state_t      r_state;
    logic [31:0] r_scnt;
    logic [31:0] r_smp;
    logic [31:0] r_sccnt;
    logic [7:0]  r_pts;
    logic [3:0]  r_lvl_idx;
    logic        r_scroll;
    logic        r_sample;
    logic        r_running;
    logic        r_over;
    logic [7:0]  r_score;
    logic [9:0]  r_level;

    logic signed [31:0] w_sub;
    logic [31:0]        w_period;
    logic [31:0]        w_scroll_last;
    logic               w_score_up;
    logic               w_lvl_up;

    function automatic logic [9:0] therm(input logic [3:0] idx);
        logic [9:0] v;
        v = '0;
        for (int i = 0; i < 10; i++) v[i] = (idx > 4'(i));
        return v;
    endfunction

    // Signed subtraction so a large level index clamps instead of wrapping.
    assign w_sub         = SCROLL_BASE - int'(r_lvl_idx) * SCROLL_STEP;
    assign w_period      = (w_sub < SCROLL_MIN) ? 32'(SCROLL_MIN) : 32'(w_sub);
    assign w_scroll_last = w_period - 32'd1;
    assign w_score_up    = (r_score != 8'hFF);
    assign w_lvl_up      = w_score_up && (r_pts == PTS_LAST) && (r_lvl_idx < LVL_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_scnt    <= '0;
            r_smp     <= '0;
            r_sccnt   <= '0;
            r_pts     <= '0;
            r_lvl_idx <= '0;
            r_scroll  <= 1'b0;
            r_sample  <= 1'b0;
            r_running <= 1'b0;
            r_over    <= 1'b0;
            r_score   <= '0;
            r_level   <= '0;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (lose) begin
                        r_state   <= S_OVER;
                        r_scroll  <= 1'b0;
                        r_sample  <= 1'b0;
                        r_running <= 1'b0;
                        r_over    <= 1'b1;
                    end else begin
                        // >= rather than == so a period that shrank below scnt fires at once
                        if (r_scnt >= w_scroll_last) begin
                            r_scroll <= 1'b1;
                            r_scnt   <= '0;
                        end else begin
                            r_scroll <= 1'b0;
                            r_scnt   <= r_scnt + 32'd1;
                        end
                        if (r_smp >= SMP_LAST) begin
                            r_sample <= 1'b1;
                            r_smp    <= '0;
                        end else begin
                            r_sample <= 1'b0;
                            r_smp    <= r_smp + 32'd1;
                        end
                        if (r_sccnt >= SCORE_LAST) begin
                            r_sccnt <= '0;
                            if (w_score_up) begin
                                r_score <= r_score + 8'd1;
                                r_pts   <= (r_pts == PTS_LAST) ? 8'd0 : r_pts + 8'd1;
                            end
                            if (w_lvl_up) begin
                                r_lvl_idx <= r_lvl_idx + 4'd1;
                                r_level   <= therm(r_lvl_idx + 4'd1);
                            end
                        end else begin
                            r_sccnt <= r_sccnt + 32'd1;
                        end
                    end
                end
                default: begin
                    r_scroll <= 1'b0;
                    r_sample <= 1'b0;
                    if (start) begin
                        r_state   <= S_PLAY;
                        r_running <= 1'b1;
                        r_over    <= 1'b0;
                        r_scnt    <= '0;
                        r_smp     <= '0;
                        r_sccnt   <= '0;
                        r_pts     <= '0;
                        r_lvl_idx <= '0;
                        r_score   <= '0;
                        r_level   <= '0;
                    end
                end
            endcase
        end
    end

    assign scroll_tick = r_scroll;
    assign sample_tick = r_sample;
    assign running     = r_running;
    assign game_over   = r_over;
    assign score       = r_score;
    assign level       = r_level;
    assign dbg_state   = r_state;
endmodule
